// File: rtl/sm_mult_pkg.sv
// Shared types and constant helpers for the sequential sign-magnitude multiplier
// and its rounding/saturation output stage.
package sm_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Magnitude width for an operand of the given total width (sign bit at MSB).
  function automatic int mag_width(input int width);
    return width - 1;
  endfunction

  // Half-LSB constant added before dropping 'frac' fraction bits (round half up).
  function automatic logic [63:0] round_const(input int frac);
    logic [63:0] rc;
    if (frac > 0) rc = 64'd1 << (frac - 1);
    else          rc = 64'd0;
    return rc;
  endfunction

endpackage

// File: rtl/sm_round_sat.sv
// Combinational round-half-up and saturate stage: full-precision sign-magnitude
// product in, operand-width Q-format result and saturation flag out.
module sm_round_sat
  import sm_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4
) (
  input  logic [2*WIDTH-2:0] full,
  output logic [WIDTH-1:0]   out_q,
  output logic               out_sat
);

  localparam int M  = mag_width(WIDTH);
  localparam int SW = 2 * M + 1;
  localparam logic [SW-1:0] RND = SW'(round_const(FRAC));

  logic          sign;
  logic [2*M-1:0] mag;
  logic [SW-1:0] sum;
  logic [SW-1:0] r;
  logic [M-1:0]  r_clamped;

  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    sign      = full[2*M];
    mag       = full[2*M-1:0];
    // One spare bit on the adder keeps the rounding carry from wrapping.
    sum       = {1'b0, mag} + RND;
    r         = sum >> FRAC;
    out_sat   = |r[SW-1:M];
    r_clamped = out_sat ? {M{1'b1}} : r[M-1:0];
    // A magnitude that rounds to zero never carries a sign.
    out_q     = {sign & (|r_clamped), r_clamped};
  end

endmodule

// File: rtl/sm_mult_seq.sv
// Multi-cycle radix-2 shift-add sign-magnitude multiplier with valid/ready
// handshakes, producing a full-precision and a rounded/saturated Q result.
module sm_mult_seq
  import sm_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-2:0] out_full,
  output logic [WIDTH-1:0]   out_q,
  output logic               out_sat
);

  localparam int M  = mag_width(WIDTH);
  localparam int PW = 2 * M;
  localparam int CW = $clog2(M + 1);

  state_t          state_q, state_d;
  logic            sign_r;
  logic [PW-1:0]   mcand_q;
  logic [M-1:0]    mplier_q;
  logic [PW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;

  logic            op_zero;
  logic            last_iter;
  logic [PW-1:0]   acc_next;
  logic            fin_sign;
  logic [WIDTH-1:0] rs_q;
  logic            rs_sat;

  always_comb begin
    op_zero   = (a[M-1:0] == '0) || (b[M-1:0] == '0);
    last_iter = (state_q == CALC) && (cnt_q == CW'(M - 1));
    acc_next  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    fin_sign  = sign_r & (acc_next != '0);
  end

  sm_round_sat #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_round_sat (
    .full    ({fin_sign, acc_next}),
    .out_q   (rs_q),
    .out_sat (rs_sat)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = op_zero ? DONE : CALC;
      end
      CALC: begin
        if (last_iter) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath; result registers load only on entry to DONE and otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_r   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_full <= '0;
      out_q    <= '0;
      out_sat  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_r   <= a[M] ^ b[M];
            mcand_q  <= PW'(a[M-1:0]);
            mplier_q <= b[M-1:0];
            acc_q    <= '0;
            cnt_q    <= '0;
            if (op_zero) begin
              out_full <= '0;
              out_q    <= '0;
              out_sat  <= 1'b0;
            end
          end
        end
        CALC: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (last_iter) begin
            out_full <= {fin_sign, acc_next};
            out_q    <= rs_q;
            out_sat  <= rs_sat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_mult_seq.sv
// Directed-vector bench for sm_mult_seq at WIDTH=8, FRAC=4.
module tb_sm_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_full;
  logic [7:0]  out_q;
  logic        out_sat;

  int n_vec = 0;
  int n_err = 0;

  sm_mult_seq #(
    .WIDTH (8),
    .FRAC  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_full  (out_full),
    .out_q     (out_q),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one operand pair, wait for the result, optionally stall the consumer.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_op,
                        input logic [14:0] ef, input logic [7:0] eq, input logic es,
                        input int elat, input int hold);
    int cyc;
    check({tag, "_rdy_pre"}, 32'(in_ready), 32'd1);
    a         = ta;
    b         = tb_op;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = 8'h5A;
    b        = 8'hA5;
    cyc      = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_lat"},   32'(cyc),       32'(elat));
    check({tag, "_full"},  32'(out_full),  32'(ef));
    check({tag, "_q"},     32'(out_q),     32'(eq));
    check({tag, "_sat"},   32'(out_sat),   32'(es));
    check({tag, "_rdy_busy"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_full"},  32'(out_full),  32'(ef));
      check({tag, "_hold_q"},     32'(out_q),     32'(eq));
      check({tag, "_hold_sat"},   32'(out_sat),   32'(es));
      check({tag, "_hold_rdy"},   32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_rdy"},   32'(in_ready),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(in_ready),  32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_full",  32'(out_full),  32'd0);
    check("rst_q",     32'(out_q),     32'd0);
    check("rst_sat",   32'(out_sat),   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    //        tag     a      b      full      q      sat  lat hold
    run_op("pos_neg", 8'h03, 8'h85, 15'h400F, 8'h81, 1'b0, 8, 0);
    run_op("neg0",    8'h80, 8'h07, 15'h0000, 8'h00, 1'b0, 1, 0);
    run_op("b_zero",  8'h05, 8'h00, 15'h0000, 8'h00, 1'b0, 1, 0);
    run_op("satur",   8'h7F, 8'hFF, 15'h7F01, 8'hFF, 1'b1, 8, 0);
    run_op("half_up", 8'h02, 8'h04, 15'h0008, 8'h01, 1'b0, 8, 0);
    run_op("rnd_to0", 8'h81, 8'h07, 15'h4007, 8'h00, 1'b0, 8, 0);
    run_op("neg_neg", 8'h8A, 8'h8C, 15'h0078, 8'h08, 1'b0, 8, 0);
    run_op("neg_half", 8'h88, 8'h01, 15'h4008, 8'h81, 1'b0, 8, 0);
    run_op("bkpr",    8'h03, 8'h85, 15'h400F, 8'h81, 1'b0, 8, 5);

    // Abort a multiply in flight with reset.
    check("abort_rdy_pre", 32'(in_ready), 32'd1);
    a        = 8'h7F;
    b        = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", 32'(in_ready),  32'd1);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_full",  32'(out_full),  32'd0);
    check("abort_q",     32'(out_q),     32'd0);
    check("abort_sat",   32'(out_sat),   32'd0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("abort_no_result", 32'(out_valid), 32'd0);
    run_op("after_rst", 8'h05, 8'h05, 15'h0019, 8'h02, 1'b0, 8, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
